// File: rtl/multi_signal_gen.sv
// Multi-channel phase-accumulator waveform generator with a strobe-synchronised register port.
// Optional PDM mixer on mixed_out is built only when MIXED_OUT_EN is defined.

module msg_channel #(
   parameter int ACC_W  = 16,
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_freq,
   input  logic              wr_duty,
   input  logic              wr_mode,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data,
   output logic [ACC_W-1:0]  acc,
   output logic              wave
);
   logic [ACC_W-1:0]  freq;
   logic [DATA_W-1:0] duty;
   logic [1:0]        mode;
   logic              en;
   logic              tick;
   logic [15:0]       lfsr;
   logic [ACC_W:0]    sum;
   logic              wave_next;

   assign sum = {1'b0, acc} + {1'b0, freq};

   always_comb begin
      wave_next = 1'b0;
      case (mode)
         2'd0:    wave_next = acc[ACC_W-1];
         2'd1:    wave_next = (acc[ACC_W-1 -: DATA_W] < duty);
         2'd2:    wave_next = lfsr[0];
         default: wave_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         freq <= '0;
         duty <= DATA_W'(1) << (DATA_W-1);
         mode <= 2'd0;
         en   <= 1'b0;
         tick <= 1'b0;
         lfsr <= 16'hACE1;
         wave <= 1'b0;
      end else begin
         tick <= 1'b0;
         // phase clear beats the running update
         if (wr_en && data[1])
            acc <= '0;
         else if (en) begin
            acc  <= sum[ACC_W-1:0];
            tick <= sum[ACC_W];
         end else
            acc <= '0;
         if (wr_freq) freq <= {freq[ACC_W-DATA_W-1:0], data};
         if (wr_duty) duty <= data;
         if (wr_mode) mode <= data[1:0];
         if (wr_en)   en   <= data[0];
         // x^16+x^14+x^13+x^11, right-shifting Fibonacci form; nonzero seed never reaches zero
         if (tick) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         wave <= en & wave_next;
      end
   end
endmodule

module multi_signal_gen #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 16,
   parameter int DATA_W   = 5,
   parameter int ADDR_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write_strobe,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data,
   output logic [CHANNELS-1:0] signal_out,
   output logic                mixed_out,
   output logic [6:0]          debug
);
   logic                             sync1, sync2, sync3, wr_pulse;
   logic [DATA_W-1:0]                ch_sel;
   logic [CHANNELS-1:0][ACC_W-1:0]   acc;
   logic [CHANNELS-1:0]              wr_freq, wr_duty, wr_mode, wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         wr_pulse <= 1'b0;
         ch_sel   <= '0;
      end else begin
         sync1    <= write_strobe;
         sync2    <= sync1;
         sync3    <= sync2;
         wr_pulse <= sync2 & ~sync3;
         if (wr_pulse && address == ADDR_W'(0)) ch_sel <= data;
      end
   end

   // channel strobes; an out-of-range ch_sel matches no channel
   always_comb begin
      wr_freq = '0;
      wr_duty = '0;
      wr_mode = '0;
      wr_en   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (wr_pulse && ch_sel == DATA_W'(c)) begin
            wr_freq[c] = (address == ADDR_W'(1));
            wr_duty[c] = (address == ADDR_W'(2));
            wr_mode[c] = (address == ADDR_W'(3));
            wr_en[c]   = (address == ADDR_W'(4));
         end
      end
   end

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         msg_channel #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_freq (wr_freq[c]),
            .wr_duty (wr_duty[c]),
            .wr_mode (wr_mode[c]),
            .wr_en   (wr_en[c]),
            .data    (data),
            .acc     (acc[c]),
            .wave    (signal_out[c])
         );
      end
   endgenerate

   assign debug = {acc[0][ACC_W-1 -: 3], wr_pulse, ch_sel[2:0]};

`ifdef MIXED_OUT_EN
   localparam int PW = $clog2(2*CHANNELS) + 1;
   logic [PW-1:0] pacc, ones, tot;

   always_comb begin
      ones = '0;
      for (int c = 0; c < CHANNELS; c++) ones = ones + PW'(signal_out[c]);
   end

   assign tot = pacc + ones;

   always_ff @(posedge clk) begin
      if (rst) begin
         pacc      <= '0;
         mixed_out <= 1'b0;
      end else if (tot >= PW'(CHANNELS)) begin
         mixed_out <= 1'b1;
         pacc      <= tot - PW'(CHANNELS);
      end else begin
         mixed_out <= 1'b0;
         pacc      <= tot;
      end
   end
`else
   assign mixed_out = 1'b0;
`endif
endmodule

// File: tb/tb_multi_signal_gen.sv
// Scoreboard bench for multi_signal_gen (CHANNELS=2, ACC_W=16, DATA_W=5).
module tb_multi_signal_gen;
   localparam int CHANNELS = 2;
   localparam int ACC_W    = 16;
   localparam int DATA_W   = 5;
   localparam int ADDR_W   = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                write_strobe = 1'b0;
   logic [ADDR_W-1:0]   address = '0;
   logic [DATA_W-1:0]   data = '0;
   logic [CHANNELS-1:0] signal_out;
   logic                mixed_out;
   logic [6:0]          debug;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sb_q[$];

   multi_signal_gen #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .write_strobe (write_strobe),
      .address      (address),
      .data         (data),
      .signal_out   (signal_out),
      .mixed_out    (mixed_out),
      .debug        (debug)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int v);
      sb_q.push_back('{tag, v});
   endtask

   task automatic pop_chk(input int obs);
      exp_t e;
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
         e = sb_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic wr(input int a, input int d);
      @(negedge clk);
      address = ADDR_W'(a);
      data = DATA_W'(d);
      write_strobe = 1'b1;
      repeat (5) @(negedge clk);
      write_strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic count_high(input int ch, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (signal_out[ch]) cnt++;
      end
   endtask

   // sync to a rising edge, then measure the following high and low runs (-1 on timeout)
   task automatic runs(input int ch, output int hi, output int lo);
      logic prev, cur;
      int n;
      bit found;
      hi = -1; lo = -1; found = 0;
      @(negedge clk);
      prev = signal_out[ch];
      for (n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         cur = signal_out[ch];
         if (!prev && cur) found = 1;
         prev = cur;
      end
      if (!found) return;
      hi = 1;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (signal_out[ch]) hi++; else break;
      end
      lo = 1;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!signal_out[ch]) lo++; else break;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, lo, cnt, cnt1, toggles;
      logic prev_m;

      // reset state
      push("rst_sig", 0); push("rst_mix", 0); push("rst_dbg", 0);
      repeat (2) @(negedge clk);
      pop_chk(signal_out); pop_chk(mixed_out); pop_chk(debug);
      rst = 1'b0;

      // write timing: strobe seen at edge N, pulse visible after N+2, register after N+3
      push("wt_pulse1", 0); push("wt_sel1", 0);
      push("wt_pulse2", 0); push("wt_sel2", 0);
      push("wt_pulse3", 1); push("wt_sel3", 0);
      push("wt_pulse4", 0); push("wt_sel4", 3);
      @(negedge clk);
      address = 3'd0; data = 5'd3; write_strobe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pop_chk(debug[3]);
         pop_chk(debug[2:0]);
      end
      write_strobe = 1'b0;
      repeat (3) @(negedge clk);
      wr(0, 0);

      // square on ch0, freq 0x0400
      wr(1, 1); wr(1, 0); wr(1, 0); wr(3, 0); wr(4, 1);
      push("sq_hi", 32); push("sq_lo", 32); push("ch1_off", 0);
      runs(0, hi, lo);
      pop_chk(hi); pop_chk(lo);
      count_high(1, 64, cnt1);
      pop_chk(cnt1);

      // pulse, duty 8
      wr(3, 1); wr(2, 8);
      push("pl8_hi", 16); push("pl8_lo", 48);
      runs(0, hi, lo);
      pop_chk(hi); pop_chk(lo);

      // duty 0 -> constant low
      wr(2, 0);
      push("pl0_cnt", 0);
      count_high(0, 128, cnt);
      pop_chk(cnt);

      // duty 31 -> all but the top slot
      wr(2, 31);
      push("pl31_hi", 62); push("pl31_lo", 2);
      runs(0, hi, lo);
      pop_chk(hi); pop_chk(lo);

      // freq 0, acc cleared, duty 1 -> static high
      wr(1, 0); wr(1, 0); wr(1, 0); wr(2, 1); wr(4, 3);
      push("static_cnt", 64);
      count_high(0, 64, cnt);
      pop_chk(cnt);

      // mixer: one of two channels high -> density 1/2
`ifdef MIXED_OUT_EN
      push("mix_ones", 4); push("mix_toggles", 7);
`else
      push("mix_ones", 0); push("mix_toggles", 0);
`endif
      cnt = 0; toggles = 0;
      @(negedge clk);
      prev_m = mixed_out;
      cnt += int'(mixed_out);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         cnt += int'(mixed_out);
         if (mixed_out != prev_m) toggles++;
         prev_m = mixed_out;
      end
      pop_chk(cnt); pop_chk(toggles);

      // out-of-range select: freq/en writes must be dropped
      wr(0, 5); wr(1, 31); wr(1, 31); wr(1, 31); wr(4, 0);
      push("oor_sel", 5); push("oor_ch0", 64); push("oor_ch1", 0);
      pop_chk(debug[2:0]);
      count_high(0, 64, cnt);
      pop_chk(cnt);
      count_high(1, 64, cnt1);
      pop_chk(cnt1);

      // noise: static with freq 0, varying once wraps occur
      wr(0, 0); wr(3, 2);
      push("noise_static", 1);
      count_high(0, 64, cnt);
      pop_chk(int'(cnt == 0 || cnt == 64));
      wr(1, 16); wr(1, 0); wr(1, 0);
      push("noise_varies", 1);
      count_high(0, 256, cnt);
      pop_chk(int'(cnt > 0 && cnt < 256));

      // reset mid-write discards the pending ch_sel write
      @(negedge clk);
      address = 3'd0; data = 5'd2; write_strobe = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      push("mid_rst_dbg", 0); push("mid_rst_sig", 0);
      repeat (6) @(negedge clk);
      pop_chk(debug); pop_chk(signal_out);

      // duty resets to 16 -> pulse mode is a 50% wave
      wr(1, 1); wr(1, 0); wr(1, 0); wr(3, 1); wr(4, 1);
      push("duty_rst_hi", 32); push("duty_rst_lo", 32);
      runs(0, hi, lo);
      pop_chk(hi); pop_chk(lo);

      chk("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
